// File: rtl/ieeedrv_trkbuf_ctl.sv
// ieeedrv_trkbuf_ctl: moves whole tracks between the disk image and the drive
// track buffer. Computes the track start sector from the zoned layout, writes
// the dirty buffer back on save_track toggles and loads the new track once the
// head has settled.
// Optional write-protect support is compiled in with `define IEEEDRV_WP_EN.
module ieeedrv_trkbuf_ctl #(
  parameter int unsigned LBA_W     = 16,
  parameter int unsigned MAX_TRACK = 154
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             drv_type,
  input  logic             mounted,
  input  logic [7:0]       track,
  input  logic             track_changing,
  input  logic             save_track,
  input  logic             sd_ack,
  output logic [LBA_W-1:0] sd_lba,
  output logic [4:0]       sd_blk_cnt,
  output logic             sd_rd,
  output logic             sd_wr,
  output logic             busy,
  output logic [7:0]       buf_track
`ifdef IEEEDRV_WP_EN
  ,
  input  logic             wp,
  output logic             wp_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_WREQ,
    S_WWAIT,
    S_RREQ,
    S_RWAIT
  } state_t;

  localparam logic [7:0] MAX_T8 = 8'(MAX_TRACK);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_save_old;
  logic             r_save_armed;
  logic             r_pending;
  logic             r_abort;
  logic             r_op_wr;
  logic [7:0]       r_target;
  logic [7:0]       r_t;
  logic [15:0]      r_acc;
  logic [LBA_W-1:0] r_lba;
  logic [4:0]       r_cnt;
  logic [7:0]       r_buf_track;

  logic             w_save_edge;
  logic             w_pending;
  logic             w_track_ok;
  logic             w_calc_done;
  logic             w_go_wr;
  logic             w_go_rd;
  logic             w_wp_refuse;
  logic             w_rd_done;
  logic [4:0]       w_spt_t;
  logic [4:0]       w_spt_tgt;

  // Sectors per track for the 4040 (is4040=1) or 8250 zoned layout.
  function automatic logic [4:0] f_spt(input logic [7:0] t, input logic is4040);
    logic [4:0] s;
    if (is4040) begin
      if      (t <= 8'd17)  s = 5'd21;
      else if (t <= 8'd24)  s = 5'd19;
      else if (t <= 8'd30)  s = 5'd18;
      else                  s = 5'd17;
    end else begin
      if      (t <= 8'd39)  s = 5'd29;
      else if (t <= 8'd53)  s = 5'd27;
      else if (t <= 8'd64)  s = 5'd25;
      else if (t <= 8'd77)  s = 5'd23;
      else if (t <= 8'd116) s = 5'd29;
      else if (t <= 8'd130) s = 5'd27;
      else if (t <= 8'd141) s = 5'd25;
      else                  s = 5'd23;
    end
    return s;
  endfunction

  // An edge seen in the same clock as the IDLE decision still wins over a
  // load, so the old buffer is written back before the new track replaces it.
  assign w_save_edge = r_save_armed && (save_track != r_save_old);
  assign w_pending   = r_pending || w_save_edge;
  assign w_track_ok  = (track != 8'd0) && (track <= MAX_T8);
  assign w_calc_done = (r_t == r_target);
  assign w_spt_t     = f_spt(r_t, drv_type);
  assign w_spt_tgt   = f_spt(r_target, drv_type);

  assign sd_rd      = (r_state == S_RREQ);
  assign sd_wr      = (r_state == S_WREQ);
  assign busy       = (r_state != S_IDLE);
  assign sd_lba     = r_lba;
  assign sd_blk_cnt = r_cnt;
  assign buf_track  = r_buf_track;

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic and one-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_go_wr     = 1'b0;
    w_go_rd     = 1'b0;
    w_wp_refuse = 1'b0;
    w_rd_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!mounted) begin
          if (w_pending && (r_buf_track != 8'd0)) begin
`ifdef IEEEDRV_WP_EN
            if (wp) begin
              w_wp_refuse = 1'b1;
            end else begin
              w_go_wr     = 1'b1;
              w_state_nxt = S_CALC;
            end
`else
            w_go_wr     = 1'b1;
            w_state_nxt = S_CALC;
`endif
          end else if (!track_changing && w_track_ok && (track != r_buf_track)) begin
            w_go_rd     = 1'b1;
            w_state_nxt = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (mounted)          w_state_nxt = S_IDLE;
        else if (w_calc_done) w_state_nxt = r_op_wr ? S_WREQ : S_RREQ;
      end
      S_WREQ: begin
        if (mounted)     w_state_nxt = S_IDLE;
        else if (sd_ack) w_state_nxt = S_WWAIT;
      end
      S_RREQ: begin
        if (mounted)     w_state_nxt = S_IDLE;
        else if (sd_ack) w_state_nxt = S_RWAIT;
      end
      S_WWAIT: begin
        if (!sd_ack) w_state_nxt = S_IDLE;
      end
      S_RWAIT: begin
        if (!sd_ack) begin
          w_rd_done   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // save_track edge detector; the first clock after reset only samples.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_save_old   <= 1'b0;
      r_save_armed <= 1'b0;
    end else begin
      r_save_old   <= save_track;
      r_save_armed <= 1'b1;
    end
  end

  // Pending write-back flag, buffer ownership and mount abort tracking.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pending   <= 1'b0;
      r_buf_track <= 8'd0;
      r_abort     <= 1'b0;
    end else begin
      if (mounted)                       r_pending <= 1'b0;
      else if (w_go_wr || w_wp_refuse)   r_pending <= 1'b0;
      else if (w_save_edge)              r_pending <= 1'b1;

      if (mounted)                       r_buf_track <= 8'd0;
      else if (w_rd_done && !r_abort)    r_buf_track <= r_target;

      // A mount during a transfer invalidates the data being read.
      if (mounted)                       r_abort <= 1'b1;
      else if (w_go_wr || w_go_rd)       r_abort <= 1'b0;
    end
  end

  // Target latch and one-track-per-clock offset accumulation.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_op_wr  <= 1'b0;
      r_target <= 8'd0;
      r_t      <= 8'd0;
      r_acc    <= '0;
      r_lba    <= '0;
      r_cnt    <= '0;
    end else if (w_go_wr || w_go_rd) begin
      r_op_wr  <= w_go_wr;
      r_target <= w_go_wr ? r_buf_track : track;
      r_t      <= 8'd1;
      r_acc    <= '0;
    end else if (r_state == S_CALC && !mounted) begin
      if (w_calc_done) begin
        r_lba <= LBA_W'(r_acc);
        r_cnt <= w_spt_tgt;
      end else begin
        r_acc <= r_acc + 16'(w_spt_t);
        r_t   <= r_t + 8'd1;
      end
    end
  end

`ifdef IEEEDRV_WP_EN
  // Single-cycle pulse for a refused write-back.
  logic r_wp_err;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_wp_err <= 1'b0;
    else          r_wp_err <= w_wp_refuse;
  end
  assign wp_err = r_wp_err;
`endif

endmodule

// File: tb/tb_ieeedrv_trkbuf_ctl.sv
// Scoreboard bench for ieeedrv_trkbuf_ctl: expected transfers are queued when
// stimulus is applied and compared when the DUT raises sd_rd/sd_wr.
module tb_ieeedrv_trkbuf_ctl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        drv_type;
  logic        mounted;
  logic [7:0]  track;
  logic        track_changing;
  logic        save_track;
  logic        sd_ack;
  logic [15:0] sd_lba;
  logic [4:0]  sd_blk_cnt;
  logic        sd_rd;
  logic        sd_wr;
  logic        busy;
  logic [7:0]  buf_track;
`ifdef IEEEDRV_WP_EN
  logic        wp;
  logic        wp_err;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    bit          wr;
    int unsigned lba;
    int unsigned cnt;
    int unsigned lat;
    int unsigned buf_after;
  } xfer_t;

  xfer_t sb[$];

  ieeedrv_trkbuf_ctl #(.LBA_W(16), .MAX_TRACK(154)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .drv_type       (drv_type),
    .mounted        (mounted),
    .track          (track),
    .track_changing (track_changing),
    .save_track     (save_track),
    .sd_ack         (sd_ack),
    .sd_lba         (sd_lba),
    .sd_blk_cnt     (sd_blk_cnt),
    .sd_rd          (sd_rd),
    .sd_wr          (sd_wr),
    .busy           (busy),
    .buf_track      (buf_track)
`ifdef IEEEDRV_WP_EN
    ,
    .wp             (wp),
    .wp_err         (wp_err)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference layout straight from the zone tables.
  function automatic int unsigned m_spt(input int unsigned t, input bit is4040);
    if (is4040) begin
      if (t <= 17) return 21;
      if (t <= 24) return 19;
      if (t <= 30) return 18;
      return 17;
    end
    if (t <= 39)  return 29;
    if (t <= 53)  return 27;
    if (t <= 64)  return 25;
    if (t <= 77)  return 23;
    if (t <= 116) return 29;
    if (t <= 130) return 27;
    if (t <= 141) return 25;
    return 23;
  endfunction

  function automatic int unsigned m_lba(input int unsigned t, input bit is4040);
    int unsigned s = 0;
    for (int unsigned i = 1; i < t; i++) s += m_spt(i, is4040);
    return s;
  endfunction

  task automatic push(input bit wr, input int unsigned lba, input int unsigned cnt,
                      input int unsigned lat, input int unsigned buf_after);
    xfer_t e;
    e.wr = wr; e.lba = lba; e.cnt = cnt; e.lat = lat; e.buf_after = buf_after;
    sb.push_back(e);
  endtask

  task automatic push_model(input bit wr, input int unsigned trk, input int unsigned buf_after);
    push(wr, m_lba(trk, drv_type), m_spt(trk, drv_type), trk, buf_after);
  endtask

  // Wait (bounded) for the next request and compare it against the scoreboard head.
  task automatic expect_req(input string tag, output xfer_t e);
    int unsigned n = 0;
    bit seen = 1'b0;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty got 0 expected 1", tag);
      $fatal(1, "scoreboard underflow");
    end
    e = sb.pop_front();
    while (!seen && n < 400) begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr) seen = 1'b1;
      else n++;
    end
    check({tag, ":req_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, ":op"},  32'({sd_wr, sd_rd}), e.wr ? 32'd2 : 32'd1);
      check({tag, ":lba"}, 32'(sd_lba), e.lba);
      check({tag, ":cnt"}, 32'(sd_blk_cnt), e.cnt);
      check({tag, ":lat"}, n, e.lat);
    end
  endtask

  task automatic wait_idle(input string tag);
    int unsigned k = 0;
    do begin
      @(negedge clk_sys);
      k++;
    end while (busy && k < 50);
    check({tag, ":idle"}, 32'(busy), 32'd0);
  endtask

  task automatic ack_xfer(input string tag, input xfer_t e);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    check({tag, ":req_drop"}, 32'({sd_wr, sd_rd}), 32'd0);
    check({tag, ":lba_hold"}, 32'(sd_lba), e.lba);
    check({tag, ":cnt_hold"}, 32'(sd_blk_cnt), e.cnt);
    @(negedge clk_sys);
    sd_ack = 1'b0;
    wait_idle(tag);
    check({tag, ":buf"}, 32'(buf_track), e.buf_after);
  endtask

  task automatic serve(input string tag);
    xfer_t e;
    expect_req(tag, e);
    ack_xfer(tag, e);
  endtask

  // Watch a quiet window and count cycles where the DUT was active.
  task automatic quiet(input string tag, input int unsigned cycles);
    int unsigned act = 0;
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge clk_sys);
      if (busy || sd_rd || sd_wr) act++;
    end
    check({tag, ":quiet"}, act, 32'd0);
  endtask

  initial begin
    xfer_t e;
    reset_n = 1'b0; drv_type = 1'b1; mounted = 1'b0; track = 8'd0;
    track_changing = 1'b1; save_track = 1'b0; sd_ack = 1'b0;
`ifdef IEEEDRV_WP_EN
    wp = 1'b0;
`endif
    repeat (3) @(negedge clk_sys);
    check("rst:rd",   32'(sd_rd), 32'd0);
    check("rst:wr",   32'(sd_wr), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:buf",  32'(buf_track), 32'd0);
    check("rst:lba",  32'(sd_lba), 32'd0);
    check("rst:cnt",  32'(sd_blk_cnt), 32'd0);

    // 4040 first load of track 18
    track = 8'd18; track_changing = 1'b0;
    push(1'b0, 357, 19, 18, 18);
    reset_n = 1'b1;
    serve("t18");

    // save toggle and track move in the same clock: write-back first
    save_track = ~save_track; track = 8'd19;
    push(1'b1, 357, 19, 18, 18);
    push(1'b0, 376, 19, 19, 19);
    serve("wb18");
    serve("t19");

    // head settling blocks the load
    track_changing = 1'b1; track = 8'd20;
    quiet("settle", 10);
    track_changing = 1'b0;
    push(1'b0, 395, 19, 20, 20);
    serve("t20");

    // illegal tracks leave the buffer alone
    track = 8'd0;
    quiet("trk0", 10);
    check("trk0:buf", 32'(buf_track), 32'd20);
    track = 8'd200;
    quiet("trk200", 10);
    check("trk200:buf", 32'(buf_track), 32'd20);

    // 8250 layout
    drv_type = 1'b0; track = 8'd78;
    push(1'b0, 2083, 29, 78, 78);
    serve("t78");
    track = 8'd40;
    push(1'b0, 1131, 27, 40, 40);
    serve("t40");

    // save edge during a read is queued and written back afterwards
    track = 8'd41;
    push_model(1'b0, 41, 41);
    expect_req("t41", e);
    save_track = ~save_track;
    ack_xfer("t41", e);
    push_model(1'b1, 41, 41);
    serve("wb41");

    track = 8'd154;
    push_model(1'b0, 154, 154);
    serve("t154");
    track = 8'd1;
    push(1'b0, 0, 29, 1, 1);
    serve("t1");

    // asynchronous reset while sd_rd is high, then the load restarts
    track = 8'd30;
    push_model(1'b0, 30, 30);
    expect_req("t30a", e);
    #2 reset_n = 1'b0;
    #1;
    check("arst:rd",   32'(sd_rd), 32'd0);
    check("arst:busy", 32'(busy), 32'd0);
    check("arst:lba",  32'(sd_lba), 32'd0);
    check("arst:cnt",  32'(sd_blk_cnt), 32'd0);
    check("arst:buf",  32'(buf_track), 32'd0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    push_model(1'b0, 30, 30);
    serve("t30b");

    // mount during RWAIT: buffer stays invalid, then the track is reloaded
    track = 8'd35;
    push_model(1'b0, 35, 0);
    expect_req("t35a", e);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    mounted = 1'b1;
    @(negedge clk_sys);
    mounted = 1'b0;
    check("mnt:buf_now", 32'(buf_track), 32'd0);
    check("mnt:busy",    32'(busy), 32'd1);
    sd_ack = 1'b0;
    wait_idle("mnt");
    check("mnt:buf_after", 32'(buf_track), 32'd0);
    push_model(1'b0, 35, 35);
    serve("t35b");

    // plain write-back without a track change
    save_track = ~save_track;
    push_model(1'b1, 35, 35);
    serve("wb35");
    quiet("wb35_after", 5);

`ifdef IEEEDRV_WP_EN
    begin
      int unsigned pulses = 0;
      int unsigned wrs = 0;
      wp = 1'b1;
      save_track = ~save_track;
      for (int unsigned i = 0; i < 20; i++) begin
        @(negedge clk_sys);
        if (wp_err) pulses++;
        if (sd_wr)  wrs++;
      end
      check("wp:err_pulses", pulses, 32'd1);
      check("wp:no_wr",      wrs, 32'd0);
      wp = 1'b0;
      quiet("wp_cleared", 5);
    end
`endif

    check("sb:drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
